// File: rtl/logic_gate_pipe_if.sv
// Valid/ready handshake bundle for logic_gate_pipe: operand side plus result side.
// The master drives operands and accepts results; the slave is the pipeline itself.
interface logic_gate_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/logic_gate_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready flow control and STAGES register stages.
// Define LOGIC_GATE_PIPE_CNT_EN to add the 16-bit accepted-output counter and its count port.
module logic_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_gate_pipe_if.slave  bus
`ifdef LOGIC_GATE_PIPE_CNT_EN
  ,
  output logic [15:0]       count
`endif
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_XOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_BUF  = 3'b111
  } op_e;

  logic [WIDTH-1:0] result;
  logic             transfer;
  logic [STAGES-1:0] valid_q;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] ready;

  // NOTE: every always_comb output gets a default before the case, so no latch is inferred.
  always_comb begin
    result = bus.a;
    case (op_e'(bus.op))
      OP_NOT:  result = ~bus.a;
      OP_AND:  result = bus.a & bus.b;
      OP_OR:   result = bus.a | bus.b;
      OP_XOR:  result = bus.a ^ bus.b;
      OP_NAND: result = ~(bus.a & bus.b);
      OP_NOR:  result = ~(bus.a | bus.b);
      OP_XNOR: result = ~(bus.a ^ bus.b);
      OP_BUF:  result = bus.a;
      default: result = bus.a;
    endcase
  end

  // A stage can load if it is empty or anything downstream of it can move; walking
  // from the output back keeps the chain free of self-referencing vector bits.
  always_comb begin
    logic downstream_ready;
    // NOTE: blocking '=' inside combinational logic, so each iteration sees the previous one.
    downstream_ready = bus.out_ready;
    ready            = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      downstream_ready = downstream_ready || !valid_q[k];
      ready[k]         = downstream_ready;
    end
  end

  assign bus.in_ready = ready[0];
  assign transfer     = bus.in_valid && ready[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      // NOTE: the data registers are reset as well so y reads 0 after reset, not stale data.
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      if (ready[0]) begin
        valid_q[0] <= transfer;
        if (transfer) begin
          data_q[0] <= result;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= valid_q[k-1];
          if (valid_q[k-1]) begin
            data_q[k] <= data_q[k-1];
          end
        end
      end
    end
  end

  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.y         = data_q[STAGES-1];

`ifdef LOGIC_GATE_PIPE_CNT_EN
  // Counts handshakes on the result side; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (valid_q[STAGES-1] && bus.out_ready) begin
      count <= count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe with STAGES = 1, 2 and 4 side by side.
// Counter checks are included when LOGIC_GATE_PIPE_CNT_EN is defined.
module tb_logic_gate_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic       v1, v2, v4;
  logic       r1, r2, r4;
  logic [2:0] op;
  logic [7:0] a, b;

  logic_gate_pipe_if #(.WIDTH(8)) if1 ();
  logic_gate_pipe_if #(.WIDTH(8)) if2 ();
  logic_gate_pipe_if #(.WIDTH(8)) if4 ();

  assign if1.in_valid = v1;  assign if1.out_ready = r1;
  assign if1.op = op;        assign if1.a = a;  assign if1.b = b;
  assign if2.in_valid = v2;  assign if2.out_ready = r2;
  assign if2.op = op;        assign if2.a = a;  assign if2.b = b;
  assign if4.in_valid = v4;  assign if4.out_ready = r4;
  assign if4.op = op;        assign if4.a = a;  assign if4.b = b;

`ifdef LOGIC_GATE_PIPE_CNT_EN
  logic [15:0] cnt1, cnt2, cnt4;
`endif

  logic_gate_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
`ifdef LOGIC_GATE_PIPE_CNT_EN
    , .count(cnt1)
`endif
  );

  logic_gate_pipe #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2)
`ifdef LOGIC_GATE_PIPE_CNT_EN
    , .count(cnt2)
`endif
  );

  logic_gate_pipe #(.WIDTH(8), .STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4)
`ifdef LOGIC_GATE_PIPE_CNT_EN
    , .count(cnt4)
`endif
  );

  // a=F0, b=CC under ops 000..111
  logic [7:0] exp_t2 [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lane(input string tag, input logic ov, input logic [7:0] oy, input int idx);
    if (idx >= 0 && idx < 8) begin
      check({tag, ".valid"}, ov, 1);
      check({tag, ".y"}, oy, exp_t2[idx]);
    end else begin
      check({tag, ".valid"}, ov, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit reached");
  end

  initial begin
    exp_t2 = '{8'h0F, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0};
    rst_n = 1'b0;
    v1 = 0; v2 = 0; v4 = 0;
    r1 = 1; r2 = 1; r4 = 1;
    op = 3'b000; a = 8'h00; b = 8'h00;

    // Reset state
    #2;
    check("rst.s2.valid", if2.out_valid, 0);
    check("rst.s2.y", if2.y, 0);
    check("rst.s2.in_ready", if2.in_ready, 1);
    check("rst.s1.valid", if1.out_valid, 0);
    check("rst.s4.valid", if4.out_valid, 0);
`ifdef LOGIC_GATE_PIPE_CNT_EN
    check("rst.s2.count", cnt2, 0);
`endif
    #10;
    rst_n = 1'b1;
    tick();

    // Single NOT of 00, latency per depth
    op = 3'b000; a = 8'h00; v1 = 1; v2 = 1; v4 = 1;
    tick();
    v1 = 0; v2 = 0; v4 = 0;
    check("t1.s1.valid", if1.out_valid, 1);
    check("t1.s1.y", if1.y, 8'hFF);
    check("t1.s2.valid_early", if2.out_valid, 0);
    tick();
    check("t1.s2.valid", if2.out_valid, 1);
    check("t1.s2.y", if2.y, 8'hFF);
    check("t1.s1.valid_done", if1.out_valid, 0);
    check("t1.s4.valid_early", if4.out_valid, 0);
    tick();
    check("t1.s2.valid_done", if2.out_valid, 0);
    check("t1.s4.valid_early2", if4.out_valid, 0);
    tick();
    check("t1.s4.valid", if4.out_valid, 1);
    check("t1.s4.y", if4.y, 8'hFF);
    tick();
    check("t1.s4.valid_done", if4.out_valid, 0);

    // All eight ops back-to-back
    a = 8'hF0; b = 8'hCC;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        op = c[2:0]; v1 = 1; v2 = 1; v4 = 1;
      end else begin
        v1 = 0; v2 = 0; v4 = 0;
      end
      tick();
      check_lane($sformatf("t2.s1.c%0d", c), if1.out_valid, if1.y, c);
      check_lane($sformatf("t2.s2.c%0d", c), if2.out_valid, if2.y, c - 1);
      check_lane($sformatf("t2.s4.c%0d", c), if4.out_valid, if4.y, c - 3);
    end
    tick();
    tick();

    // Fill STAGES=2 while stalled, then release
    r2 = 0; op = 3'b011; a = 8'hAA; b = 8'h0F; v2 = 1;
    #1;
    check("t3.in_ready0", if2.in_ready, 1);
    check("t3.valid0", if2.out_valid, 0);
    tick();
    op = 3'b100;
    #1;
    check("t3.in_ready1", if2.in_ready, 1);
    check("t3.valid1", if2.out_valid, 0);
    tick();
    check("t3.valid_full", if2.out_valid, 1);
    check("t3.y_full", if2.y, 8'hA5);
    op = 3'b101;
    #1;
    check("t3.in_ready_full", if2.in_ready, 0);
    for (int s = 0; s < 3; s++) begin
      tick();
      check($sformatf("t3.stall%0d.valid", s), if2.out_valid, 1);
      check($sformatf("t3.stall%0d.y", s), if2.y, 8'hA5);
      check($sformatf("t3.stall%0d.in_ready", s), if2.in_ready, 0);
    end
    r2 = 1;
    #1;
    check("t3.in_ready_release", if2.in_ready, 1);
    tick();
    check("t3.item1.valid", if2.out_valid, 1);
    check("t3.item1.y", if2.y, 8'hF5);
    op = 3'b110;
    tick();
    v2 = 0;
    check("t3.item2.valid", if2.out_valid, 1);
    check("t3.item2.y", if2.y, 8'h50);
    tick();
    check("t3.item3.valid", if2.out_valid, 1);
    check("t3.item3.y", if2.y, 8'h5A);
    tick();
    check("t3.drained", if2.out_valid, 0);

    // Asynchronous reset with two items in flight
    r2 = 0; v2 = 1; op = 3'b000; a = 8'h0F;
    tick();
    op = 3'b001; a = 8'hFF; b = 8'h3C;
    tick();
    v2 = 0;
    #1;
    check("t4.pre.in_ready", if2.in_ready, 0);
    check("t4.pre.valid", if2.out_valid, 1);
    check("t4.pre.y", if2.y, 8'hF0);
    rst_n = 1'b0;
    #1;
    check("t4.rst.valid", if2.out_valid, 0);
    check("t4.rst.y", if2.y, 0);
    check("t4.rst.in_ready", if2.in_ready, 1);
`ifdef LOGIC_GATE_PIPE_CNT_EN
    check("t4.rst.count", cnt2, 0);
`endif
    #2;
    rst_n = 1'b1;
    r2 = 1;
    for (int s = 0; s < 4; s++) begin
      tick();
      check($sformatf("t4.after%0d.valid", s), if2.out_valid, 0);
    end

    // STAGES=4 fills to four entries, fifth held, then drains in order
    r4 = 0; a = 8'hF0; b = 8'hCC; v4 = 1;
    for (int k = 0; k < 4; k++) begin
      op = k[2:0];
      #1;
      check($sformatf("t5.s4.in_ready%0d", k), if4.in_ready, 1);
      tick();
    end
    op = 3'b100;
    #1;
    check("t5.s4.in_ready_full", if4.in_ready, 0);
    check("t5.s4.valid_full", if4.out_valid, 1);
    check("t5.s4.y_full", if4.y, 8'h0F);
    tick();
    check("t5.s4.y_stall", if4.y, 8'h0F);
    check("t5.s4.in_ready_stall", if4.in_ready, 0);
    r4 = 1;
    #1;
    check("t5.s4.in_ready_release", if4.in_ready, 1);
    tick();
    v4 = 0;
    check("t5.s4.out1", if4.y, 8'hC0);
    check("t5.s4.out1.valid", if4.out_valid, 1);
    tick();
    check("t5.s4.out2", if4.y, 8'hFC);
    tick();
    check("t5.s4.out3", if4.y, 8'h3C);
    tick();
    check("t5.s4.out4", if4.y, 8'h3F);
    check("t5.s4.out4.valid", if4.out_valid, 1);
    tick();
    check("t5.s4.drained", if4.out_valid, 0);

    // STAGES=1 stall: one entry, second held
    r1 = 0; op = 3'b010; v1 = 1;
    #1;
    check("t5.s1.in_ready0", if1.in_ready, 1);
    tick();
    op = 3'b101;
    #1;
    check("t5.s1.in_ready_full", if1.in_ready, 0);
    check("t5.s1.valid_full", if1.out_valid, 1);
    check("t5.s1.y_full", if1.y, 8'hFC);
    tick();
    check("t5.s1.y_stall", if1.y, 8'hFC);
    check("t5.s1.in_ready_stall", if1.in_ready, 0);
    r1 = 1;
    #1;
    check("t5.s1.in_ready_release", if1.in_ready, 1);
    tick();
    v1 = 0;
    check("t5.s1.out1.valid", if1.out_valid, 1);
    check("t5.s1.out1.y", if1.y, 8'h03);
    tick();
    check("t5.s1.drained", if1.out_valid, 0);

`ifdef LOGIC_GATE_PIPE_CNT_EN
    // Counter preload to FFFF, then wrap
    check("t6.start", cnt2, 0);
    r2 = 1; v2 = 1; op = 3'b111; a = 8'h5A;
    repeat (65535) tick();
    v2 = 0;
    tick();
    tick();
    check("t6.ffff", cnt2, 16'hFFFF);
    v2 = 1;
    tick();
    v2 = 0;
    tick();
    tick();
    check("t6.wrap", cnt2, 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
